ym2413_write_sched: RTL and testbench

YM2413_WRITE_SCHED -- requirements
Module: ym2413_write_sched

---
 rtl/ym2413_pkg.sv | 27 ++
 rtl/ym2413_wr_fifo.sv | 62 ++++++
 rtl/ym2413_write_sched.sv | 173 +++++++++++++++++
 tb/tb_ym2413_write_sched.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym2413_pkg.sv
// Shared constants and types for the YM2413 write scheduler: bus decode
// addresses, default inter-write gaps, FIFO entry layout and FSM states.
package ym2413_pkg;

    localparam logic [14:0] ADDR_SEL     = 15'h1010;  // CPU $9010: register select
    localparam logic [14:0] ADDR_DAT     = 15'h1030;  // CPU $9030: register data
    localparam int          DEF_ADDR_GAP = 12;
    localparam int          DEF_DATA_GAP = 84;
    localparam int          ENTRY_W      = 9;

    typedef enum logic {
        ENTRY_ADDR = 1'b0,
        ENTRY_DATA = 1'b1
    } entry_type_e;

    typedef struct packed {
        entry_type_e typ;
        logic [7:0]  data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ym2413_wr_fifo.sv
// Ring-buffer FIFO holding captured CPU writes until the scheduler issues them.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module ym2413_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   push_ok
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             pop_ok;

    assign full      = (level_reg == LVL_W'(DEPTH));
    assign empty     = (level_reg == '0);
    assign pop_ok    = pop & ~empty;
    assign push_ok   = push & (~full | pop_ok);
    assign head_data = mem[rd_ptr_reg];
    assign level     = level_reg;

    // Storage: only written on accepted pushes, contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/ym2413_write_sched.sv
// Captures CPU writes to $9010/$9030, queues them, and replays them to the
// YM2413 register file with the minimum spacing the chip needs after an
// address write (ADDR_GAP) or a data write (DATA_GAP).
module ym2413_write_sched
    import ym2413_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_GAP   = DEF_ADDR_GAP,
    parameter int DATA_GAP   = DEF_DATA_GAP
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  cpu_d,
    input  logic [14:0]                 cpu_a,
    input  logic                        cpu_ce_n,
    input  logic                        cpu_rw,
    output logic [7:0]                  reg_d,
    output logic                        sel_reg,
    output logic                        sel_dat,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        fifo_full,
    output logic                        busy,
    output logic                        overflow
);
    localparam int MAX_GAP = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
    localparam int CNT_W   = $clog2(MAX_GAP + 1);

    logic               wr_sel;
    logic               wr_dat;
    logic               wr_sel_hist_reg;
    logic               wr_dat_hist_reg;
    logic               cap_sel;
    logic               cap_dat;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_data;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;
    fifo_entry_t        issue_entry_reg;
    sched_state_e       state_reg;
    sched_state_e       state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               strobe_addr_reg;
    logic               strobe_data_reg;
    logic [7:0]         reg_d_reg;
    logic               overflow_reg;

    // Bus decode; a held strobe captures only on its first sampled edge
    assign wr_sel  = ~cpu_ce_n & ~cpu_rw & (cpu_a == ADDR_SEL);
    assign wr_dat  = ~cpu_ce_n & ~cpu_rw & (cpu_a == ADDR_DAT);
    assign cap_sel = wr_sel & ~wr_sel_hist_reg;
    assign cap_dat = wr_dat & ~wr_dat_hist_reg;
    assign push    = cap_sel | cap_dat;

    // Build the entry to queue: type bit plus the data sampled on the capture edge
    always_comb begin
        push_entry      = '0;
        push_entry.typ  = cap_dat ? ENTRY_DATA : ENTRY_ADDR;
        push_entry.data = cpu_d;
    end

    assign head_entry = fifo_entry_t'(head_data);

    ym2413_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_ok   (push_ok)
    );

    // Strobe history for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_sel_hist_reg <= 1'b0;
            wr_dat_hist_reg <= 1'b0;
        end else begin
            wr_sel_hist_reg <= wr_sel;
            wr_dat_hist_reg <= wr_dat;
        end
    end

    // Sticky drop flag: set whenever a capture finds no room
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (push & ~push_ok) begin
            overflow_reg <= 1'b1;
        end
    end

    // Scheduler next-state: pop in IDLE, one ISSUE cycle, then count out the gap.
    // The gap counter covers the cycles between ISSUE and the following IDLE,
    // so ISSUE-to-ISSUE spacing equals the gap when the FIFO stays non-empty.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                cnt_next   = (issue_entry_reg.typ == ENTRY_DATA) ? CNT_W'(DATA_GAP - 2)
                                                                 : CNT_W'(ADDR_GAP - 2);
            end
            ST_WAIT: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next   = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Scheduler state, gap counter and the entry being issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            issue_entry_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (pop) begin
                issue_entry_reg <= head_entry;
            end
        end
    end

    // Registered register-file strobes; reg_d holds its value between issues
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_addr_reg <= 1'b0;
            strobe_data_reg <= 1'b0;
            reg_d_reg       <= 8'h00;
        end else begin
            strobe_addr_reg <= (state_reg == ST_ISSUE) && (issue_entry_reg.typ == ENTRY_ADDR);
            strobe_data_reg <= (state_reg == ST_ISSUE) && (issue_entry_reg.typ == ENTRY_DATA);
            if (state_reg == ST_ISSUE) begin
                reg_d_reg <= issue_entry_reg.data;
            end
        end
    end

    assign sel_reg  = strobe_addr_reg;
    assign sel_dat  = strobe_data_reg;
    assign reg_d    = reg_d_reg;
    assign busy     = (state_reg != ST_IDLE) | ~fifo_empty;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_ym2413_write_sched.sv
// Directed testbench for ym2413_write_sched: decode, latency, spacing,
// overflow, full-FIFO push/pop, pointer wrap and asynchronous reset.
module tb_ym2413_write_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  cpu_d;
    logic [14:0] cpu_a;
    logic        cpu_ce_n;
    logic        cpu_rw;
    logic [7:0]  reg_d;
    logic        sel_reg;
    logic        sel_dat;
    logic [3:0]  fifo_level;
    logic        fifo_full;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        logic       typ;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    ev_t  log_q[$];
    ev_t  mon_ev;
    logic exp_t[$];
    logic [7:0] exp_d[$];

    ym2413_write_sched dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_d      (cpu_d),
        .cpu_a      (cpu_a),
        .cpu_ce_n   (cpu_ce_n),
        .cpu_rw     (cpu_rw),
        .reg_d      (reg_d),
        .sel_reg    (sel_reg),
        .sel_dat    (sel_dat),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Record every register-file strobe, one line per issued write
    always @(negedge clk) begin
        if (sel_reg === 1'b1 || sel_dat === 1'b1) begin
            mon_ev.typ = sel_dat;
            mon_ev.d   = reg_d;
            mon_ev.cyc = edge_n;
            log_q.push_back(mon_ev);
            $display("issue edge=%0d %s d=%h", edge_n, sel_dat ? "sel_dat" : "sel_reg", reg_d);
        end
        if (sel_reg === 1'b1 && sel_dat === 1'b1) begin
            errors++;
            $display("FAIL both_sel edge=%0d sel_reg=1 sel_dat=1, want at most one high", edge_n);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_ce_n = 1'b1;
        cpu_rw   = 1'b1;
        cpu_a    = 15'h0000;
        cpu_d    = 8'h00;
    endtask

    task automatic bus_wr(input logic [14:0] a, input logic [7:0] d);
        cpu_ce_n = 1'b0;
        cpu_rw   = 1'b0;
        cpu_a    = a;
        cpu_d    = d;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b after %0d cycles, want 0", tag, busy, n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        log_q.delete();
    endtask

    task automatic test_reset();
        bus_idle();
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({reg_d, sel_reg, sel_dat, fifo_level, fifo_full, busy, overflow} !== 17'h0) begin
            errors++;
            $display("FAIL reset_state got reg_d=%h sel=%b%b lvl=%0d full=%b busy=%b ovf=%b, want all 0",
                     reg_d, sel_reg, sel_dat, fifo_level, fifo_full, busy, overflow);
        end
        reset = 1'b0;
        step();
        log_q.delete();
    endtask

    task automatic test_ignore();
        logic [14:0] t_a  [3];
        logic        t_rw [3];
        logic        t_ce [3];
        t_a  = '{15'h1010, 15'h1011, 15'h1010};
        t_rw = '{1'b1, 1'b0, 1'b0};
        t_ce = '{1'b0, 1'b0, 1'b1};
        for (int p = 0; p < 3; p++) begin
            cpu_a    = t_a[p];
            cpu_rw   = t_rw[p];
            cpu_ce_n = t_ce[p];
            cpu_d    = 8'hE0 + 8'(p);
            step();
            checks++;
            if (fifo_level !== 4'd0) begin
                errors++;
                $display("FAIL ignore_level%0d got=%0d want=0", p, fifo_level);
            end
            step();
            bus_idle();
            step();
        end
        repeat (20) step();
        checks++;
        if (log_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_issue got issues=%0d busy=%b want issues=0 busy=0", log_q.size(), busy);
        end
    endtask

    task automatic test_latency_pair();
        int k;
        log_q.delete();
        bus_wr(15'h1010, 8'h30);
        step();
        k = edge_n;
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL pair_level_push got=%0d want=1", fifo_level);
        end
        bus_wr(15'h1030, 8'h21);
        step();
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL pair_level_pushpop got=%0d want=1", fifo_level);
        end
        bus_idle();
        step();
        checks++;
        if ({sel_reg, sel_dat, reg_d} !== {1'b1, 1'b0, 8'h30}) begin
            errors++;
            $display("FAIL pair_latency got sel_reg=%b sel_dat=%b reg_d=%h want 1 0 30", sel_reg, sel_dat, reg_d);
        end
        step();
        checks++;
        if ({sel_reg, reg_d} !== {1'b0, 8'h30}) begin
            errors++;
            $display("FAIL pair_hold got sel_reg=%b reg_d=%h want 0 30", sel_reg, reg_d);
        end
        wait_idle(300, "pair");
        checks++;
        if (log_q.size() != 2) begin
            errors++;
            $display("FAIL pair_count got=%0d want=2", log_q.size());
        end
        for (int j = 0; j < log_q.size() && j < 2; j++) begin
            logic       et;
            logic [7:0] ed;
            int         ec;
            et = (j == 1);
            ed = (j == 1) ? 8'h21 : 8'h30;
            ec = (j == 1) ? k + 14 : k + 2;
            checks++;
            if (log_q[j].typ !== et || log_q[j].d !== ed || log_q[j].cyc != ec) begin
                errors++;
                $display("FAIL pair_issue%0d got typ=%b d=%h edge=%0d want typ=%b d=%h edge=%0d",
                         j, log_q[j].typ, log_q[j].d, log_q[j].cyc, et, ed, ec);
            end
        end
    endtask

    task automatic test_hold();
        int peak;
        peak = 0;
        log_q.delete();
        bus_wr(15'h1030, 8'h55);
        for (int c = 0; c < 5; c++) begin
            step();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        bus_idle();
        step();
        wait_idle(300, "hold");
        checks++;
        if (peak != 1) begin
            errors++;
            $display("FAIL hold_peak_level got=%0d want=1", peak);
        end
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL hold_count got=%0d want=1", log_q.size());
        end
        if (log_q.size() > 0) begin
            checks++;
            if (log_q[0].typ !== 1'b1 || log_q[0].d !== 8'h55) begin
                errors++;
                $display("FAIL hold_issue got typ=%b d=%h want typ=1 d=55", log_q[0].typ, log_q[0].d);
            end
        end
    endtask

    task automatic test_burst_overflow();
        logic seen_full;
        seen_full = 1'b0;
        log_q.delete();
        exp_t.delete();
        exp_d.delete();
        bus_wr(15'h1030, 8'hA0);
        exp_t.push_back(1'b1);
        exp_d.push_back(8'hA0);
        step();
        bus_idle();
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            bus_wr((i % 2 == 1) ? 15'h1030 : 15'h1010, 8'h40 + 8'(i));
            if (i < 8) begin
                exp_t.push_back(i % 2 == 1);
                exp_d.push_back(8'h40 + 8'(i));
            end
            step();
            if (fifo_full === 1'b1) seen_full = 1'b1;
        end
        bus_idle();
        step();
        checks++;
        if (fifo_level !== 4'd8 || fifo_full !== 1'b1 || seen_full !== 1'b1) begin
            errors++;
            $display("FAIL burst_full got lvl=%0d full=%b seen=%b want 8 1 1", fifo_level, fifo_full, seen_full);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_overflow got=%b want=1", overflow);
        end
        wait_idle(1500, "burst");
        checks++;
        if (log_q.size() != 9) begin
            errors++;
            $display("FAIL burst_count got=%0d want=9", log_q.size());
        end
        for (int j = 0; j < log_q.size() && j < 9; j++) begin
            checks++;
            if (log_q[j].typ !== exp_t[j] || log_q[j].d !== exp_d[j]) begin
                errors++;
                $display("FAIL burst_issue%0d got typ=%b d=%h want typ=%b d=%h",
                         j, log_q[j].typ, log_q[j].d, exp_t[j], exp_d[j]);
            end
            if (j > 0) begin
                int want_gap;
                want_gap = exp_t[j-1] ? 84 : 12;
                checks++;
                if (log_q[j].cyc - log_q[j-1].cyc != want_gap) begin
                    errors++;
                    $display("FAIL burst_gap%0d got=%0d want=%0d", j, log_q[j].cyc - log_q[j-1].cyc, want_gap);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_overflow_sticky got=%b want=1", overflow);
        end
    endtask

    task automatic test_full_pushpop();
        pulse_reset();
        exp_t.delete();
        exp_d.delete();
        bus_wr(15'h1030, 8'h11);
        exp_t.push_back(1'b1);
        exp_d.push_back(8'h11);
        step();                                   // edge k: capture, first pop at k+1
        bus_idle();
        step();
        step();
        for (int i = 0; i < 8; i++) begin         // edges k+3 .. k+10
            bus_wr((i % 2 == 1) ? 15'h1030 : 15'h1010, 8'h60 + 8'(i));
            exp_t.push_back(i % 2 == 1);
            exp_d.push_back(8'h60 + 8'(i));
            step();
        end
        bus_idle();
        repeat (74) step();                       // now at edge k+84, next pop at k+85
        checks++;
        if (fifo_level !== 4'd8 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_before got lvl=%0d full=%b want 8 1", fifo_level, fifo_full);
        end
        bus_wr(15'h1010, 8'h77);
        exp_t.push_back(1'b0);
        exp_d.push_back(8'h77);
        step();                                   // edge k+85: pop and push together
        checks++;
        if (fifo_level !== 4'd8 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop got lvl=%0d full=%b ovf=%b want 8 1 0", fifo_level, fifo_full, overflow);
        end
        bus_wr(15'h1030, 8'h88);
        step();                                   // edge k+86: no pop, push dropped
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_drop got lvl=%0d ovf=%b want 8 1", fifo_level, overflow);
        end
        bus_idle();
        wait_idle(1500, "full");
        checks++;
        if (log_q.size() != 10) begin
            errors++;
            $display("FAIL full_count got=%0d want=10", log_q.size());
        end
        for (int j = 0; j < log_q.size() && j < 10; j++) begin
            checks++;
            if (log_q[j].typ !== exp_t[j] || log_q[j].d !== exp_d[j]) begin
                errors++;
                $display("FAIL full_issue%0d got typ=%b d=%h want typ=%b d=%h",
                         j, log_q[j].typ, log_q[j].d, exp_t[j], exp_d[j]);
            end
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int g = 0; g < 4; g++) begin
            for (int w = 0; w < 5; w++) begin
                bus_wr(15'h1010, 8'h80 + 8'(g * 5 + w));
                step();
                bus_idle();
                step();
            end
            wait_idle(300, "wrap");
        end
        checks++;
        if (log_q.size() != 20) begin
            errors++;
            $display("FAIL wrap_count got=%0d want=20", log_q.size());
        end
        for (int j = 0; j < log_q.size() && j < 20; j++) begin
            checks++;
            if (log_q[j].typ !== 1'b0 || log_q[j].d !== 8'h80 + 8'(j)) begin
                errors++;
                $display("FAIL wrap_issue%0d got typ=%b d=%h want typ=0 d=%h", j, log_q[j].typ, log_q[j].d, 8'h80 + 8'(j));
            end
        end
        checks++;
        if (overflow !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL wrap_final got ovf=%b lvl=%0d want 0 0", overflow, fifo_level);
        end
    endtask

    task automatic test_reset_mid_wait();
        log_q.delete();
        bus_wr(15'h1030, 8'hC0);
        step();
        bus_idle();
        step();
        step();
        bus_wr(15'h1010, 8'hC1);
        step();
        bus_idle();
        step();
        bus_wr(15'h1030, 8'hC2);
        step();
        bus_idle();
        step();
        bus_wr(15'h1010, 8'hC3);
        step();
        bus_idle();
        step();
        checks++;
        if (fifo_level !== 4'd3 || busy !== 1'b1 || reg_d !== 8'hC0) begin
            errors++;
            $display("FAIL rst_pre got lvl=%0d busy=%b reg_d=%h want 3 1 c0", fifo_level, busy, reg_d);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({reg_d, sel_reg, sel_dat, fifo_level, fifo_full, busy, overflow} !== 17'h0) begin
            errors++;
            $display("FAIL rst_async got reg_d=%h sel=%b%b lvl=%0d full=%b busy=%b ovf=%b, want all 0",
                     reg_d, sel_reg, sel_dat, fifo_level, fifo_full, busy, overflow);
        end
        log_q.delete();
        step();
        step();
        reset = 1'b0;
        repeat (200) step();
        checks++;
        if (log_q.size() != 0 || fifo_level !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after got issues=%0d lvl=%0d busy=%b want 0 0 0", log_q.size(), fifo_level, busy);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_ignore();
        test_latency_pair();
        test_hold();
        test_burst_overflow();
        test_full_pushpop();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
